qupls_mem_accept: RTL and testbench

QUPLS_MEM_ACCEPT -- requirements
Module: qupls_mem_accept

---
 rtl/qupls_mem_accept_pkg.sv | 25 ++
 rtl/qupls_mem_accept.sv | 158 +++++++++++++++
 tb/tb_qupls_mem_accept.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qupls_mem_accept_pkg.sv
// ============================================================================
//  Module      : QuplsPkg
//  Description : Shared ROB index/bitmask types and the memory-accept queue
//                entry used by qupls_mem_accept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package QuplsPkg;

    localparam int ROB_ENTRIES = 16;

    typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;
    typedef logic [ROB_ENTRIES-1:0]         rob_bitmask_t;

    // One queued memory op: valid (cleared by stomp), ROB index, store flag.
    typedef struct packed {
        logic     v;
        rob_ndx_t ndx;
        logic     st;
    } mem_acc_entry_t;

endpackage

`default_nettype wire

// File: rtl/qupls_mem_accept.sv
// ============================================================================
//  Module      : qupls_mem_accept
//  Description : Accepts up to two memory ops per cycle from the scheduler
//                into an in-order circular queue, issues them to a single
//                memory port under an outstanding-request limit and a
//                store-serialisation rule, and returns completions to the ROB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qupls_mem_accept
    import QuplsPkg::*;
#(
    parameter int QDEPTH  = 8,
    parameter int MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  rob_ndx_t     ndx0,
    input  rob_ndx_t     ndx1,
    input  logic         ndx0v,
    input  logic         ndx1v,
    input  logic         st0,
    input  logic         st1,
    input  rob_bitmask_t robentry_stomp,
    output logic         accept_rdy,
    output logic         req_v,
    output rob_ndx_t     req_ndx,
    output logic         req_st,
    input  logic         req_rdy,
    input  logic         resp_v,
    input  rob_ndx_t     resp_ndx,
    input  logic         resp_err,
    output logic         done_v,
    output rob_ndx_t     done_ndx,
    output logic         done_err,
    output logic         ovf
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    mem_acc_entry_t r_q [QDEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [OW-1:0]  r_out_cnt;
    rob_bitmask_t   r_out_mask;
    logic           r_ovf;
    logic           r_done_v;
    rob_ndx_t       r_done_ndx;
    logic           r_done_err;

    mem_acc_entry_t w_head;
    logic           w_not_empty;
    logic           w_head_live;
    logic           w_store_ok;
    logic           w_req_v;
    logic           w_issue;
    logic           w_pop_dead;
    logic           w_deq;
    logic [CW-1:0]  w_free;
    logic           w_take0;
    logic           w_take1;
    logic           w_drop;
    logic [PW-1:0]  w_tail1;
    logic           w_resp_hit;
    rob_bitmask_t   w_mask_next;

    // Head selection, issue qualification, enqueue capacity and mask update.
    always_comb begin
        w_head      = r_q[r_head];
        w_not_empty = (r_count != '0);
        // A head stomped this very cycle must not be presented.
        w_head_live = w_not_empty && w_head.v && !robentry_stomp[w_head.ndx];
        // Stores go out alone; since the queue is in order, a waiting store
        // also holds back everything younger.
        w_store_ok  = !w_head.st || (r_out_cnt == '0);
        w_req_v     = !rst && w_head_live && (r_out_cnt < OW'(MAX_OUT)) && w_store_ok;
        w_issue     = w_req_v && req_rdy;
        // Dead (stomped) heads are retired one per cycle with no request.
        w_pop_dead  = !rst && w_not_empty && !w_head.v;
        w_deq       = w_issue || w_pop_dead;
        // A slot freed by this cycle's dequeue can be reused immediately.
        w_free      = CW'(QDEPTH) - r_count + CW'(w_deq);
        w_take0     = ndx0v && (w_free != '0);
        w_take1     = ndx1v && (w_free > CW'(w_take0));
        w_drop      = (ndx0v && !w_take0) || (ndx1v && !w_take1);
        w_tail1     = r_tail + PW'(w_take0);
        w_resp_hit  = resp_v && r_out_mask[resp_ndx];
        w_mask_next = r_out_mask;
        if (w_resp_hit) begin
            w_mask_next[resp_ndx] = 1'b0;
        end
        if (w_issue) begin
            w_mask_next[w_head.ndx] = 1'b1;
        end
    end

    // Queue storage, pointers, occupancy, outstanding tracking and overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_out_cnt  <= '0;
            r_out_mask <= '0;
            r_ovf      <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (robentry_stomp[r_q[i].ndx]) begin
                    r_q[i].v <= 1'b0;
                end
            end
            if (w_take0) begin
                r_q[r_tail] <= '{v: !robentry_stomp[ndx0], ndx: ndx0, st: st0};
            end
            if (w_take1) begin
                r_q[w_tail1] <= '{v: !robentry_stomp[ndx1], ndx: ndx1, st: st1};
            end
            r_tail     <= w_tail1 + PW'(w_take1);
            r_head     <= r_head + PW'(w_deq);
            r_count    <= r_count + CW'(w_take0) + CW'(w_take1) - CW'(w_deq);
            r_out_cnt  <= r_out_cnt + OW'(w_issue) - OW'(w_resp_hit);
            r_out_mask <= w_mask_next;
            r_ovf      <= r_ovf | w_drop;
        end
    end

    // Completion register: only responses to live, unsquashed requests report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_v   <= 1'b0;
            r_done_ndx <= '0;
            r_done_err <= 1'b0;
        end else begin
            r_done_v   <= w_resp_hit && !robentry_stomp[resp_ndx];
            r_done_ndx <= resp_ndx;
            r_done_err <= resp_err;
        end
    end

    assign accept_rdy = (CW'(QDEPTH) - r_count) >= CW'(2);
    assign req_v      = w_req_v;
    assign req_ndx    = w_head.ndx;
    assign req_st     = w_head.st;
    assign done_v     = r_done_v;
    assign done_ndx   = r_done_ndx;
    assign done_err   = r_done_err;
    assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_qupls_mem_accept.sv
// ============================================================================
//  Module      : tb_qupls_mem_accept
//  Description : Scoreboard bench for qupls_mem_accept: directed scenarios
//                followed by randomized traffic against a queue-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qupls_mem_accept;
    import QuplsPkg::*;

    localparam int QDEPTH  = 8;
    localparam int MAX_OUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    rob_ndx_t     ndx0, ndx1;
    logic         ndx0v, ndx1v, st0, st1;
    rob_bitmask_t robentry_stomp;
    logic         accept_rdy, req_v, req_st, req_rdy;
    rob_ndx_t     req_ndx;
    logic         resp_v, resp_err;
    rob_ndx_t     resp_ndx;
    logic         done_v, done_err, ovf;
    rob_ndx_t     done_ndx;

    always #5 clk = ~clk;

    qupls_mem_accept #(.QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .ndx0(ndx0), .ndx1(ndx1), .ndx0v(ndx0v), .ndx1v(ndx1v),
        .st0(st0), .st1(st1), .robentry_stomp(robentry_stomp),
        .accept_rdy(accept_rdy),
        .req_v(req_v), .req_ndx(req_ndx), .req_st(req_st), .req_rdy(req_rdy),
        .resp_v(resp_v), .resp_ndx(resp_ndx), .resp_err(resp_err),
        .done_v(done_v), .done_ndx(done_ndx), .done_err(done_err),
        .ovf(ovf)
    );

    typedef struct { rob_ndx_t ndx; logic st; } req_t;
    typedef struct { rob_ndx_t ndx; logic err; int cyc; } done_t;

    req_t     pend_q[$];   // ops still expected to be requested, oldest first
    rob_ndx_t out_q[$];    // requests seen on the port, not yet answered
    done_t    done_q[$];   // completions expected from the DUT
    int       errors = 0;
    int       checks = 0;
    int       cycle_no = 0;
    bit       no_push = 1'b0;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; ndx0v = 1'b0; ndx1v = 1'b0; st0 = 1'b0; st1 = 1'b0;
        ndx0 = '0; ndx1 = '0; robentry_stomp = '0;
        resp_v = 1'b0; resp_ndx = '0; resp_err = 1'b0;
    endtask

    // Reference model: what this cycle's inputs mean at the transaction level.
    task automatic apply_model();
        req_t keep[$];
        if (rst) begin
            pend_q.delete(); out_q.delete(); done_q.delete();
            return;
        end
        if (!no_push) begin
            if (ndx0v) pend_q.push_back('{ndx0, st0});
            if (ndx1v) pend_q.push_back('{ndx1, st1});
        end
        foreach (pend_q[i]) if (!robentry_stomp[pend_q[i].ndx]) keep.push_back(pend_q[i]);
        pend_q = keep;
        if (resp_v) begin
            for (int k = 0; k < out_q.size(); k++) begin
                if (out_q[k] == resp_ndx) begin
                    out_q.delete(k);
                    if (!robentry_stomp[resp_ndx]) done_q.push_back('{resp_ndx, resp_err, cycle_no});
                    break;
                end
            end
        end
    endtask

    task automatic cyc();
        apply_model();
        @(posedge clk); #1;
        set_idle(); #1;
    endtask

    task automatic do_reset();
        set_idle(); rst = 1'b1;
        apply_model();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; #1;
    endtask

    task automatic drain();
        int n = 0;
        req_rdy = 1'b1;
        while ((pend_q.size() != 0 || out_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            if (out_q.size() != 0) begin
                resp_v = 1'b1; resp_ndx = out_q[0]; resp_err = 1'($urandom_range(1, 0));
            end
            cyc(); n++;
        end
        check("drain_within_budget", 32'(n < 200), 1);
    endtask

    function automatic bit busy(input int n);
        foreach (pend_q[i]) if (int'(pend_q[i].ndx) == n) return 1'b1;
        foreach (out_q[i]) if (int'(out_q[i]) == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick_free(input int excl);
        for (int t = 0; t < 32; t++) begin
            int n = int'($urandom_range(ROB_ENTRIES - 1, 0));
            if (n != excl && !busy(n)) return n;
        end
        return -1;
    endfunction

    // Monitor: request order/rules and completions against the scoreboard.
    always @(negedge clk) begin : monitor
        req_t  e;
        done_t d;
        bit    due;
        if (!rst) begin
            if (req_v) begin
                if (req_st) check("store_alone_outstanding", out_q.size(), 0);
                check("outstanding_below_max", 32'(out_q.size() < MAX_OUT), 1);
            end
            if (req_v && req_rdy) begin
                if (pend_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got ndx %0d, expected no request (t=%0t)", req_ndx, $time);
                end else begin
                    e = pend_q.pop_front();
                    check("req_ndx", 32'(req_ndx), 32'(e.ndx));
                    check("req_st", 32'(req_st), 32'(e.st));
                end
                out_q.push_back(req_ndx);
            end
            due = (done_q.size() != 0) && (done_q[0].cyc < cycle_no);
            if (done_v || due) begin
                if (!due) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done ndx %0d, expected none (t=%0t)", done_ndx, $time);
                end else begin
                    d = done_q.pop_front();
                    check("done_v", 32'(done_v), 1);
                    check("done_ndx", 32'(done_ndx), 32'(d.ndx));
                    check("done_err", 32'(done_err), 32'(d.err));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int a, b, k;
        set_idle(); rst = 1'b1; req_rdy = 1'b0;
        do_reset();
        check("reset_accept_rdy", 32'(accept_rdy), 1);
        check("reset_req_v", 32'(req_v), 0);
        check("reset_done_v", 32'(done_v), 0);
        check("reset_ovf", 32'(ovf), 0);

        // Dual issue of two loads, then a response.
        req_rdy = 1'b1;
        ndx0v = 1; ndx0 = 3; ndx1v = 1; ndx1 = 5; cyc();
        check("dual_first_req_v", 32'(req_v), 1);
        check("dual_first_ndx", 32'(req_ndx), 3);
        cyc();
        check("dual_second_ndx", 32'(req_ndx), 5);
        cyc();
        resp_v = 1; resp_ndx = 3; cyc();
        check("resp3_done_v", 32'(done_v), 1);
        check("resp3_done_ndx", 32'(done_ndx), 3);
        drain();

        // Store waits for all outstanding loads.
        ndx0v = 1; ndx0 = 2; ndx1v = 1; ndx1 = 4; cyc();
        cyc();
        ndx0v = 1; ndx0 = 7; st0 = 1; cyc();
        check("store_blocked_a", 32'(req_v), 0);
        cyc();
        check("store_blocked_b", 32'(req_v), 0);
        resp_v = 1; resp_ndx = 2; cyc();
        check("store_blocked_c", 32'(req_v), 0);
        resp_v = 1; resp_ndx = 4; cyc();
        check("store_req_v", 32'(req_v), 1);
        check("store_req_ndx", 32'(req_ndx), 7);
        check("store_req_st", 32'(req_st), 1);
        drain();

        // Fill to capacity, then overflow.
        req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ndx0v = 1; ndx0 = rob_ndx_t'(2*i); ndx1v = 1; ndx1 = rob_ndx_t'(2*i + 1); cyc();
        end
        check("accept_rdy_count6", 32'(accept_rdy), 1);
        ndx0v = 1; ndx0 = 6; cyc();
        check("accept_rdy_count7", 32'(accept_rdy), 0);
        ndx0v = 1; ndx0 = 7; cyc();
        check("ovf_at_full", 32'(ovf), 0);
        no_push = 1'b1; ndx0v = 1; ndx0 = 8; cyc(); no_push = 1'b0;
        check("ovf_set", 32'(ovf), 1);
        check("accept_rdy_full", 32'(accept_rdy), 0);
        cyc();
        check("ovf_sticky", 32'(ovf), 1);
        drain();
        check("ovf_sticky_after_drain", 32'(ovf), 1);
        do_reset();
        check("ovf_cleared", 32'(ovf), 0);

        // Stomp a queued entry.
        req_rdy = 1'b0;
        ndx0v = 1; ndx0 = 1; ndx1v = 1; ndx1 = 2; cyc();
        ndx0v = 1; ndx0 = 3; cyc();
        robentry_stomp = rob_bitmask_t'(1) << 2; cyc();
        drain();
        resp_v = 1; resp_ndx = 2; cyc();
        check("stomped_resp_no_done", 32'(done_v), 0);

        // Outstanding limit.
        req_rdy = 1'b1;
        ndx0v = 1; ndx0 = 10; ndx1v = 1; ndx1 = 11; cyc();
        ndx0v = 1; ndx0 = 12; ndx1v = 1; ndx1 = 13; cyc();
        ndx0v = 1; ndx0 = 14; cyc();
        repeat (4) cyc();
        check("max_out_requests", out_q.size(), MAX_OUT);
        check("max_out_req_v", 32'(req_v), 0);
        resp_v = 1; resp_ndx = 10; cyc();
        check("fifth_req_v", 32'(req_v), 1);
        check("fifth_req_ndx", 32'(req_ndx), 14);
        drain();

        // Reset mid-operation.
        req_rdy = 1'b1;
        ndx0v = 1; ndx0 = 1; ndx1v = 1; ndx1 = 2; cyc();
        cyc(); cyc();
        req_rdy = 1'b0;
        ndx0v = 1; ndx0 = 3; ndx1v = 1; ndx1 = 4; cyc();
        ndx0v = 1; ndx0 = 5; cyc();
        rst = 1; ndx0v = 1; ndx0 = 9; cyc();
        check("midrst_req_v", 32'(req_v), 0);
        check("midrst_accept_rdy", 32'(accept_rdy), 1);
        resp_v = 1; resp_ndx = 1; cyc();
        check("midrst_late_done", 32'(done_v), 0);
        req_rdy = 1'b1;
        repeat (4) cyc();
        check("midrst_no_req", 32'(req_v), 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req_rdy = ($urandom_range(3, 0) != 0);
            if (accept_rdy && $urandom_range(1, 0) == 1) begin
                a = pick_free(-1);
                if (a >= 0) begin
                    ndx0v = 1; ndx0 = rob_ndx_t'(a); st0 = ($urandom_range(4, 0) == 0);
                    if ($urandom_range(1, 0) == 1) begin
                        b = pick_free(a);
                        if (b >= 0) begin
                            ndx1v = 1; ndx1 = rob_ndx_t'(b); st1 = ($urandom_range(4, 0) == 0);
                        end
                    end
                end
            end
            if (pend_q.size() != 0 && $urandom_range(9, 0) == 0) begin
                k = int'($urandom_range(pend_q.size() - 1, 0));
                robentry_stomp[pend_q[k].ndx] = 1'b1;
            end
            if (out_q.size() != 0 && $urandom_range(2, 0) == 0) begin
                k = int'($urandom_range(out_q.size() - 1, 0));
                resp_v = 1; resp_ndx = out_q[k]; resp_err = 1'($urandom_range(1, 0));
                if ($urandom_range(7, 0) == 0) robentry_stomp[resp_ndx] = 1'b1;
            end
            cyc();
        end
        drain();
        check("random_no_ovf", 32'(ovf), 0);
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
